// File: rtl/alu_result_display.sv
// Holds the latest {carry, result} from the 4-bit ALU and shows it on a two-digit multiplexed 7-segment display.
// Optional build macro DECIMAL_DISPLAY_EN: show the 5-bit value in decimal instead of as hex nibble plus carry.
module alu_result_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [3:0] res_data,
    input  logic       res_carry,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              xfer;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic              slot;
    logic [3:0]        digit_lo;
    logic [3:0]        digit_hi;
    logic [3:0]        cap_lo;
    logic [3:0]        cap_hi;
    logic [3:0]        digit;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign xfer = res_valid & res_ready;
    assign dp   = 1'b1;

`ifdef DECIMAL_DISPLAY_EN
    logic [4:0] value;

    // Binary 0..31 to two decimal digits by compare/subtract; registered at capture.
    always_comb begin
        value  = {res_carry, res_data};
        cap_hi = 4'd0;
        cap_lo = value[3:0];
        if (value >= 5'd30) begin
            cap_hi = 4'd3;
            cap_lo = 4'(value - 5'd30);
        end else if (value >= 5'd20) begin
            cap_hi = 4'd2;
            cap_lo = 4'(value - 5'd20);
        end else if (value >= 5'd10) begin
            cap_hi = 4'd1;
            cap_lo = 4'(value - 5'd10);
        end
    end
`else
    assign cap_lo = res_data;
    assign cap_hi = {3'b000, res_carry};
`endif

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (xfer) state_next = HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) state_next = SHOW;
            SHOW:    if (xfer) state_next = HOLD;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            res_ready <= 1'b1;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            res_ready <= (state_next != HOLD);
            if (state == HOLD && state_next == HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_lo <= 4'd0;
            digit_hi <= 4'd0;
        end else if (xfer) begin
            digit_lo <= cap_lo;
            digit_hi <= cap_hi;
        end
    end

    // Scan runs freely from reset and is never realigned by a capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            slot    <= 1'b0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            slot    <= ~slot;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    assign digit = slot ? digit_hi : digit_lo;

    always_ff @(posedge clk) begin
        if (rst || state == EMPTY) begin
            seg <= 7'h7F;
            an  <= 4'hF;
        end else begin
            seg <= hex_to_seg(digit);
            an  <= slot ? 4'b1101 : 4'b1110;
        end
    end

endmodule
